// File: rtl/ripple_count_pkg.sv
// Shared encodings for the ripple counter controller and its datapath.
// Purely declarative: no latency or flow control of its own.
package ripple_count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // A run is in progress (counting or held) in these states.
  function automatic logic state_is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

  // A new start command is only honoured outside a run.
  function automatic logic state_accepts_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/count_core.sv
// WIDTH-bit synchronous up-counter of falling-edge toggle stages; clr wins over en.
// Latency: q updates on the falling edge after clr/en; no backpressure.
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic toggle;
    logic bit_q;

    // A stage toggles when enabled and every lower stage is at 1.
    if (i == 0) begin : g_lsb
      assign toggle = en;
    end else begin : g_upper
      assign toggle = en & (&q[i-1:0]);
    end

    always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
        bit_q <= 1'b0;
      end else if (clr) begin
        bit_q <= 1'b0;
      end else if (toggle) begin
        bit_q <= ~bit_q;
      end
    end

    assign q[i] = bit_q;
  end

endmodule

// File: rtl/ripple_count_ctrl.sv
// Start/pause/stop sequencer running count_core to a latched terminal count (one-shot or reload).
// Latency: one falling edge from command to registered count/busy/done; no backpressure.
module ripple_count_ctrl
  import ripple_count_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;

  logic             core_clr;
  logic             core_en;
  logic             active;
  logic             start_ok;
  logic             at_term;
  logic             next_hits_term;
  logic [WIDTH:0]   count_inc;

  assign active    = state_is_active(state);
  assign start_ok  = state_accepts_start(state);
  assign at_term   = (count == term_q);
  // One extra bit so the compare cannot alias through a wrap at the maximum term.
  assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
  assign next_hits_term = (count_inc == {1'b0, term_q});

  always_comb begin
    core_clr = 1'b0;
    core_en  = 1'b0;
    if (stop) begin
      core_clr = 1'b1;
    end else if (start && start_ok) begin
      core_clr = 1'b1;
    end else if (active && !pause) begin
      // Sitting at term while still running only happens in reload: wrap to zero.
      if (at_term) begin
        core_clr = 1'b1;
      end else begin
        core_en = 1'b1;
      end
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (core_clr),
    .en   (core_en),
    .q    (count)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      term_q <= '0;
      mode_q <= MODE_ONESHOT;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (start && start_ok) begin
        term_q <= term;
        mode_q <= mode;
        if (term != '0) begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end else if (mode == MODE_RELOAD) begin
          state <= ST_RUN;
          busy  <= 1'b1;
          done  <= 1'b1;
        end else begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (active) begin
        if (pause) begin
          state <= ST_PAUSE;
        end else begin
          // Leaving PAUSE advances on the same edge so each paused edge costs one cycle.
          state <= ST_RUN;
          if (at_term) begin
            if (term_q == '0) begin
              done <= 1'b1;
            end
          end else if (next_hits_term) begin
            done <= 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
          end
        end
      end
    end
  end

  a_count_bounded: assert property (@(negedge clk) disable iff (reset) count <= term_q);

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl: directed vector table, hand corner sequences, random vs model.
module tb_ripple_count_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] term = '0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  ripple_count_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .stop (stop),
    .pause(pause),
    .mode (mode),
    .term (term),
    .count(count),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [W-1:0] term;
    logic [W-1:0] e_count;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: a run is either active or not; counts are plain integers.
  logic m_active;
  int   m_count;
  int   m_term;
  logic m_mode;
  logic m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic pa, input logic md,
                     input int tm, input int ec, input logic eb, input logic ed);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.mode = md;
    v.term = W'(tm); v.e_count = W'(ec); v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa, input logic md, input int tm);
    start = st; stop = sp; pause = pa; mode = md; term = W'(tm);
  endtask

  // Advance one active (falling) edge and settle just after it.
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_count = 0; m_term = 0; m_mode = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic pa, input logic md, input int tm);
    m_done = 1'b0;
    if (sp) begin
      m_active = 1'b0;
      m_count = 0;
    end else if (st && !m_active) begin
      m_term = tm;
      m_mode = md;
      m_count = 0;
      if (tm == 0) begin
        m_done = 1'b1;
        m_active = md;
      end else begin
        m_active = 1'b1;
      end
    end else if (m_active && !pa) begin
      m_count = (m_count == m_term) ? 0 : m_count + 1;
      if (m_count == m_term) begin
        m_done = 1'b1;
        if (!m_mode) m_active = 1'b0;
      end
    end
  endtask

  initial begin
    logic r_st, r_sp, r_pa, r_md;
    int   r_tm;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("reset.count", 32'(count), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    #1 reset = 1'b0;

    // One-shot term=5
    add(1,0,0,0,5, 0,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 2,1,0);
    add(0,0,0,0,0, 3,1,0);
    add(0,0,0,0,0, 4,1,0);
    add(0,0,0,0,0, 5,0,1);
    add(0,0,0,0,0, 5,0,0);
    // Auto-reload term=3
    add(1,0,0,1,3, 0,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 2,1,0);
    add(0,0,0,0,0, 3,1,1);
    add(0,0,0,0,0, 0,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 2,1,0);
    add(0,0,0,0,0, 3,1,1);
    add(0,0,0,0,0, 0,1,0);
    add(0,1,0,0,0, 0,0,0);
    // term=0 one-shot, then term=0 reload
    add(1,0,0,0,0, 0,0,1);
    add(0,0,0,0,0, 0,0,0);
    add(1,0,0,1,0, 0,1,1);
    add(0,0,0,0,0, 0,1,1);
    add(0,1,0,0,0, 0,0,0);
    // Pause for two edges at count=2
    add(1,0,0,0,4, 0,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 2,1,0);
    add(0,0,1,0,0, 2,1,0);
    add(0,0,1,0,0, 2,1,0);
    add(0,0,0,0,0, 3,1,0);
    add(0,0,0,0,0, 4,0,1);
    // stop together with start at count=4
    add(1,0,0,0,9, 0,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 2,1,0);
    add(0,0,0,0,0, 3,1,0);
    add(0,0,0,0,0, 4,1,0);
    add(1,1,0,0,7, 0,0,0);
    add(0,0,0,0,0, 0,0,0);
    // start while running is ignored
    add(1,0,0,0,2, 0,1,0);
    add(1,0,0,0,1, 1,1,0);
    add(0,0,0,0,0, 2,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode, int'(vecs[i].term));
      cycle();
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].e_done));
    end

    // Maximum terminal count runs to 15 without wrapping
    drive(1,0,0,0,15);
    cycle();
    chk("max.start.count", 32'(count), 0);
    drive(0,0,0,0,0);
    for (int k = 1; k <= 15; k++) begin
      cycle();
      chk($sformatf("max.count%0d", k), 32'(count), 32'(k));
      chk($sformatf("max.done%0d", k), 32'(done), (k == 15) ? 32'd1 : 32'd0);
    end
    cycle();
    chk("max.hold.count", 32'(count), 15);
    chk("max.hold.done", 32'(done), 0);

    // Asynchronous reset mid-run at count=3
    drive(1,0,0,1,8);
    cycle();
    drive(0,0,0,0,0);
    for (int k = 0; k < 3; k++) cycle();
    chk("midrst.pre.count", 32'(count), 3);
    reset = 1'b1;
    #1;
    chk("midrst.count", 32'(count), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    #2 reset = 1'b0;

    // Random stimulus against the reference model
    cycle();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      r_st = ($urandom_range(0, 3) == 0);
      r_sp = ($urandom_range(0, 31) == 0);
      r_pa = ($urandom_range(0, 3) == 0);
      r_md = 1'($urandom_range(0, 1));
      r_tm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      drive(r_st, r_sp, r_pa, r_md, r_tm);
      cycle();
      model_edge(r_st, r_sp, r_pa, r_md, r_tm);
      chk($sformatf("rnd%0d.count", n), 32'(count), 32'(m_count));
      chk($sformatf("rnd%0d.busy", n), 32'(busy), 32'(m_active));
      chk($sformatf("rnd%0d.done", n), 32'(done), 32'(m_done));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
